// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified memory port arbiter.
// State encoding, owner identifiers and the wait-state counter width.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic OWN_CPU = 1'b0;
    localparam logic OWN_DMA = 1'b1;

    localparam int CNT_W = 4;

endpackage

// File: rtl/arb_rr2.sv
// Two-way request picker: lone requester wins, ties go to the port
// that was not granted last (rr_en=1) or to the CPU (rr_en=0).
module arb_rr2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_gnt,
    input  logic       rr_en,
    output logic       gnt
);

    always_comb begin
        gnt = OWN_CPU;
        unique case (req)
            2'b10:   gnt = OWN_DMA;
            2'b11:   gnt = rr_en ? ~last_gnt : OWN_CPU;
            default: gnt = OWN_CPU;
        endcase
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between the CPU and a DMA master, one access
// at a time, with wait states for a fixed memory read latency.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1,
    parameter int RR_EN   = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_ready,
    output logic [DATA_W-1:0] cpu_rdata,
    input  logic              dma_req,
    input  logic              dma_we,
    input  logic [ADDR_W-1:0] dma_addr,
    input  logic [DATA_W-1:0] dma_wdata,
    output logic              dma_ready,
    output logic [DATA_W-1:0] dma_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              owner,
    output logic              busy
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LAT - 1);
    localparam bit RR_ON = (RR_EN != 0);

    state_t state, state_nx;
    logic [CNT_W-1:0]  cnt;
    logic              last_gnt;
    logic              gnt;
    logic              lat_we;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              any_req;

    assign any_req = cpu_req | dma_req;

    arb_rr2 u_arb (
        .req      ({dma_req, cpu_req}),
        .last_gnt (last_gnt),
        .rr_en    (RR_ON),
        .gnt      (gnt)
    );

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (any_req) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = DONE;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            last_gnt  <= OWN_DMA;
            owner     <= OWN_CPU;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            cpu_rdata <= '0;
            dma_rdata <= '0;
        end else begin
            state <= state_nx;
            if (state == IDLE && any_req) begin
                owner     <= gnt;
                last_gnt  <= gnt;
                lat_we    <= (gnt == OWN_DMA) ? dma_we : cpu_we;
                lat_addr  <= (gnt == OWN_DMA) ? dma_addr : cpu_addr;
                lat_wdata <= (gnt == OWN_DMA) ? dma_wdata : cpu_wdata;
            end
            if (state == ISSUE) cnt <= CNT_INIT;
            if (state == WAIT) begin
                if (cnt != '0) begin
                    cnt <= cnt - 1'b1;
                end else if (!lat_we) begin
                    // Only reads update the owner's data register.
                    if (owner == OWN_DMA) dma_rdata <= mem_rdata;
                    else                  cpu_rdata <= mem_rdata;
                end
            end
        end
    end

    assign mem_en    = (state == ISSUE);
    assign mem_we    = mem_en & lat_we;
    assign mem_addr  = lat_addr;
    assign mem_wdata = lat_wdata;
    assign cpu_ready = (state == DONE) && (owner == OWN_CPU);
    assign dma_ready = (state == DONE) && (owner == OWN_DMA);
    assign busy      = (state != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: one instance with MEM_LAT=3/RR_EN=1 and
// one with MEM_LAT=1/RR_EN=0, checked against a transaction-level model.
module tb_mem_port_arbiter;

    localparam int LAT_A = 3;
    localparam int LAT_B = 1;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic mem_clr = 1'b1;
    always #5 clk = ~clk;

    logic        cpu_we = 1'b0, dma_we = 1'b0;
    logic [7:0]  cpu_addr = '0, dma_addr = '0;
    logic [31:0] cpu_wdata = '0, dma_wdata = '0;

    logic        a_cpu_req = 1'b0, a_dma_req = 1'b0;
    logic        a_cpu_ready, a_dma_ready, a_mem_en, a_mem_we;
    logic        a_owner, a_busy;
    logic [31:0] a_cpu_rdata, a_dma_rdata, a_mem_wdata, a_mem_rdata;
    logic [7:0]  a_mem_addr;

    logic        b_cpu_req = 1'b0, b_dma_req = 1'b0;
    logic        b_cpu_ready, b_dma_ready, b_mem_en, b_mem_we;
    logic        b_owner, b_busy;
    logic [31:0] b_cpu_rdata, b_dma_rdata, b_mem_wdata, b_mem_rdata;
    logic [7:0]  b_mem_addr;

    int checks = 0;
    int errors = 0;

    logic [31:0] ref_mem [256];
    logic [31:0] amem [256];
    logic        awritten [256];
    int          a_rd_cnt = 0;
    logic [7:0]  a_rd_addr = '0;

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT_A), .RR_EN(1)) u_dut_a (
        .clk(clk), .rst(rst),
        .cpu_req(a_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(a_cpu_ready), .cpu_rdata(a_cpu_rdata),
        .dma_req(a_dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ready(a_dma_ready), .dma_rdata(a_dma_rdata),
        .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr),
        .mem_wdata(a_mem_wdata), .mem_rdata(a_mem_rdata),
        .owner(a_owner), .busy(a_busy)
    );

    mem_port_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(LAT_B), .RR_EN(0)) u_dut_b (
        .clk(clk), .rst(rst),
        .cpu_req(b_cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr),
        .cpu_wdata(cpu_wdata), .cpu_ready(b_cpu_ready), .cpu_rdata(b_cpu_rdata),
        .dma_req(b_dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wdata(dma_wdata), .dma_ready(b_dma_ready), .dma_rdata(b_dma_rdata),
        .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr),
        .mem_wdata(b_mem_wdata), .mem_rdata(b_mem_rdata),
        .owner(b_owner), .busy(b_busy)
    );

    function automatic logic [31:0] init_val(input logic [7:0] a);
        return {a, ~a, a ^ 8'h5C, {a[3:0], a[7:4]} ^ 8'hA7};
    endfunction

    // Memory for A: read data is valid only in the cycle MEM_LAT after issue.
    always @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 256; i++) awritten[i] <= 1'b0;
        end else if (a_mem_en && a_mem_we) begin
            amem[a_mem_addr]     <= a_mem_wdata;
            awritten[a_mem_addr] <= 1'b1;
        end
        if (a_mem_en) begin
            a_rd_cnt  <= LAT_A;
            a_rd_addr <= a_mem_addr;
        end else if (a_rd_cnt != 0) begin
            a_rd_cnt <= a_rd_cnt - 1;
        end
    end

    always_comb begin
        a_mem_rdata = 32'hBAD0_BAD0;
        if (a_rd_cnt == 1)
            a_mem_rdata = awritten[a_rd_addr] ? amem[a_rd_addr] : init_val(a_rd_addr);
    end

    always_comb begin
        b_mem_rdata = {24'hA5A5A5, b_mem_addr};
        if (b_mem_addr == 8'h10) b_mem_rdata = 32'hDEADBEEF;
    end

    task automatic do_reset();
        a_cpu_req = 1'b0; a_dma_req = 1'b0;
        b_cpu_req = 1'b0; b_dma_req = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic idle_ticks(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(negedge clk);
        @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", a_busy); end
        checks++; if (a_cpu_ready !== 1'b0) begin errors++; $display("FAIL reset_cpu_ready: got %b want 0", a_cpu_ready); end
        checks++; if (a_dma_ready !== 1'b0) begin errors++; $display("FAIL reset_dma_ready: got %b want 0", a_dma_ready); end
        checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL reset_mem_en: got %b want 0", a_mem_en); end
        checks++; if (a_mem_we !== 1'b0) begin errors++; $display("FAIL reset_mem_we: got %b want 0", a_mem_we); end
        checks++; if (a_mem_addr !== 8'h00) begin errors++; $display("FAIL reset_mem_addr: got %h want 00", a_mem_addr); end
        checks++; if (a_owner !== 1'b0) begin errors++; $display("FAIL reset_owner: got %b want 0", a_owner); end
        checks++; if (a_cpu_rdata !== 32'h0) begin errors++; $display("FAIL reset_cpu_rdata: got %h want 0", a_cpu_rdata); end
        checks++; if (a_dma_rdata !== 32'h0) begin errors++; $display("FAIL reset_dma_rdata: got %h want 0", a_dma_rdata); end
        checks++; if (b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_busy: got %b want 0", b_busy); end
        mem_clr = 1'b0;
        rst = 1'b1;
    endtask

    task automatic test_dma_write();
        logic [31:0] prev;
        int en_cnt, rk, cr;
        prev = a_dma_rdata;
        en_cnt = 0; rk = -1; cr = 0;
        a_dma_req = 1'b1; dma_we = 1'b1;
        dma_addr = 8'h20; dma_wdata = 32'h12345678;
        ref_mem[8'h20] = 32'h12345678;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (a_mem_en) en_cnt++;
            if (a_cpu_ready) cr++;
            if (k == 1) begin
                checks++; if (a_mem_en !== 1'b1 || a_mem_we !== 1'b1) begin errors++; $display("FAIL wr_strobe: got en=%b we=%b want 1 1", a_mem_en, a_mem_we); end
                checks++; if (a_mem_addr !== 8'h20) begin errors++; $display("FAIL wr_addr: got %h want 20", a_mem_addr); end
                checks++; if (a_mem_wdata !== 32'h12345678) begin errors++; $display("FAIL wr_data: got %h want 12345678", a_mem_wdata); end
            end
            if (a_dma_ready && rk < 0) begin rk = k; a_dma_req = 1'b0; end
        end
        dma_we = 1'b0;
        checks++; if (en_cnt != 1) begin errors++; $display("FAIL wr_en_count: got %0d want 1", en_cnt); end
        checks++; if (rk != LAT_A + 2) begin errors++; $display("FAIL wr_latency: got %0d want %0d", rk, LAT_A + 2); end
        checks++; if (a_dma_rdata !== prev) begin errors++; $display("FAIL wr_rdata_kept: got %h want %h", a_dma_rdata, prev); end
        checks++; if (a_owner !== 1'b1) begin errors++; $display("FAIL wr_owner: got %b want 1", a_owner); end
        checks++; if (cr != 0) begin errors++; $display("FAIL wr_cpu_ready: got %0d pulses want 0", cr); end
    endtask

    task automatic test_cpu_read_lat1();
        int rk, n, dn;
        rk = -1; n = 0; dn = 0;
        b_cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h10;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (b_mem_en !== 1'b1 || b_mem_we !== 1'b0) begin errors++; $display("FAIL rd1_strobe: got en=%b we=%b want 1 0", b_mem_en, b_mem_we); end
            end
            if (b_dma_ready) dn++;
            if (b_cpu_ready) begin n++; rk = k; b_cpu_req = 1'b0; end
        end
        checks++; if (rk != 3) begin errors++; $display("FAIL rd1_latency: got %0d want 3", rk); end
        checks++; if (n != 1) begin errors++; $display("FAIL rd1_pulses: got %0d want 1", n); end
        checks++; if (b_cpu_rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd1_rdata: got %h want deadbeef", b_cpu_rdata); end
        checks++; if (dn != 0) begin errors++; $display("FAIL rd1_dma_ready: got %0d want 0", dn); end
    endtask

    task automatic test_round_robin();
        int port [4];
        int at [4];
        int n;
        n = 0;
        do_reset();
        cpu_we = 1'b0; dma_we = 1'b0;
        cpu_addr = 8'h51; dma_addr = 8'h62;
        a_cpu_req = 1'b1; a_dma_req = 1'b1;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            checks++; if (a_cpu_ready && a_dma_ready) begin errors++; $display("FAIL rr_both_ready: got 1 1 want exclusive"); end
            if ((a_cpu_ready || a_dma_ready) && n < 4) begin
                port[n] = a_dma_ready ? 1 : 0;
                at[n] = k;
                checks++;
                if (a_dma_ready && a_dma_rdata !== ref_mem[8'h62]) begin errors++; $display("FAIL rr_dma_rdata: got %h want %h", a_dma_rdata, ref_mem[8'h62]); end
                if (a_cpu_ready && a_cpu_rdata !== ref_mem[8'h51]) begin errors++; $display("FAIL rr_cpu_rdata: got %h want %h", a_cpu_rdata, ref_mem[8'h51]); end
                n++;
                if (n == 4) begin a_cpu_req = 1'b0; a_dma_req = 1'b0; end
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL rr_count: got %0d want 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (port[i] != (i % 2)) begin errors++; $display("FAIL rr_order[%0d]: got %0d want %0d", i, port[i], i % 2); end
            checks++; if (at[i] != LAT_A + 2 + (LAT_A + 3) * i) begin errors++; $display("FAIL rr_time[%0d]: got %0d want %0d", i, at[i], LAT_A + 2 + (LAT_A + 3) * i); end
        end
    endtask

    task automatic test_fixed_priority();
        int port [4];
        int at [4];
        int n;
        n = 0;
        cpu_we = 1'b0; dma_we = 1'b0;
        cpu_addr = 8'h10; dma_addr = 8'h11;
        b_cpu_req = 1'b1; b_dma_req = 1'b1;
        for (int k = 1; k <= 30; k++) begin
            @(negedge clk);
            if ((b_cpu_ready || b_dma_ready) && n < 4) begin
                port[n] = b_dma_ready ? 1 : 0;
                at[n] = k;
                n++;
                if (n == 3) b_cpu_req = 1'b0;
                if (n == 4) begin
                    b_dma_req = 1'b0;
                    checks++; if (b_dma_rdata !== 32'hA5A5A511) begin errors++; $display("FAIL fp_dma_rdata: got %h want a5a5a511", b_dma_rdata); end
                end
            end
        end
        checks++; if (n != 4) begin errors++; $display("FAIL fp_count: got %0d want 4", n); end
        for (int i = 0; i < n; i++) begin
            checks++; if (port[i] != ((i == 3) ? 1 : 0)) begin errors++; $display("FAIL fp_order[%0d]: got %0d want %0d", i, port[i], (i == 3) ? 1 : 0); end
            checks++; if (at[i] != 3 + 4 * i) begin errors++; $display("FAIL fp_time[%0d]: got %0d want %0d", i, at[i], 3 + 4 * i); end
        end
    endtask

    task automatic test_addr_change();
        int n, rk;
        n = 0; rk = -1;
        a_cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h33;
        for (int k = 1; k <= 9; k++) begin
            @(negedge clk);
            if (k == 1) begin
                checks++; if (a_mem_en !== 1'b1 || a_mem_addr !== 8'h33) begin errors++; $display("FAIL ac_issue: got en=%b addr=%h want 1 33", a_mem_en, a_mem_addr); end
            end
            if (k == 2) begin a_cpu_req = 1'b0; cpu_addr = 8'hFF; end
            if (k == 3) begin
                checks++; if (a_mem_addr !== 8'h33) begin errors++; $display("FAIL ac_hold: got %h want 33", a_mem_addr); end
            end
            if (a_cpu_ready) begin n++; rk = k; end
        end
        checks++; if (n != 1) begin errors++; $display("FAIL ac_pulses: got %0d want 1", n); end
        checks++; if (rk != LAT_A + 2) begin errors++; $display("FAIL ac_latency: got %0d want %0d", rk, LAT_A + 2); end
        checks++; if (a_cpu_rdata !== ref_mem[8'h33]) begin errors++; $display("FAIL ac_rdata: got %h want %h", a_cpu_rdata, ref_mem[8'h33]); end
    endtask

    task automatic test_reset_mid();
        int n, rk;
        n = 0; rk = -1;
        a_cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 8'h44;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (k == 3) begin rst = 1'b0; a_cpu_req = 1'b0; end
            if (k == 4) begin
                checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL rm_busy: got %b want 0", a_busy); end
                checks++; if (a_mem_en !== 1'b0) begin errors++; $display("FAIL rm_mem_en: got %b want 0", a_mem_en); end
                checks++; if (a_cpu_rdata !== 32'h0 || a_owner !== 1'b0) begin errors++; $display("FAIL rm_outputs: got rdata=%h owner=%b want 0 0", a_cpu_rdata, a_owner); end
                rst = 1'b1;
            end
            if (a_cpu_ready || a_dma_ready) n++;
        end
        checks++; if (n != 0) begin errors++; $display("FAIL rm_no_ready: got %0d pulses want 0", n); end
        a_cpu_req = 1'b1; cpu_addr = 8'h45;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk);
            if (a_cpu_ready) begin rk = k; a_cpu_req = 1'b0; end
        end
        checks++; if (rk != LAT_A + 2) begin errors++; $display("FAIL rm_fresh_latency: got %0d want %0d", rk, LAT_A + 2); end
        checks++; if (a_cpu_rdata !== ref_mem[8'h45]) begin errors++; $display("FAIL rm_fresh_rdata: got %h want %h", a_cpu_rdata, ref_mem[8'h45]); end
    endtask

    // Requesters behave randomly; the model grants whole transactions when
    // the port is free and predicts issue/ready cycles from the latency rule.
    task automatic test_random();
        logic        pend [2];
        logic        we [2];
        logic [7:0]  ad [2];
        logic [31:0] wd [2];
        logic        rdy [2];
        int          issue_c, ready_c, free_c, last, w;
        logic        e_own, e_we, gnt_any;
        logic [7:0]  e_ad;
        logic [31:0] e_wd, e_rd;
        do_reset();
        for (int m = 0; m < 2; m++) begin pend[m] = 0; we[m] = 0; ad[m] = 0; wd[m] = 0; end
        issue_c = -1; ready_c = -1; free_c = 0; last = 1;
        e_own = 0; e_we = 0; e_ad = 0; e_wd = 0; e_rd = 0; gnt_any = 0;
        for (int c = 0; c < 3000; c++) begin
            rdy[0] = (c == ready_c) && !e_own;
            rdy[1] = (c == ready_c) && e_own;
            checks++; if (a_cpu_ready !== rdy[0]) begin errors++; $display("FAIL rnd_cpu_ready@%0d: got %b want %b", c, a_cpu_ready, rdy[0]); end
            checks++; if (a_dma_ready !== rdy[1]) begin errors++; $display("FAIL rnd_dma_ready@%0d: got %b want %b", c, a_dma_ready, rdy[1]); end
            checks++; if (a_mem_en !== (c == issue_c)) begin errors++; $display("FAIL rnd_mem_en@%0d: got %b want %b", c, a_mem_en, c == issue_c); end
            checks++; if (a_busy !== (c >= issue_c && c < free_c)) begin errors++; $display("FAIL rnd_busy@%0d: got %b want %b", c, a_busy, c >= issue_c && c < free_c); end
            if (c == issue_c) begin
                checks++; if (a_mem_addr !== e_ad || a_mem_we !== e_we) begin errors++; $display("FAIL rnd_issue@%0d: got addr=%h we=%b want %h %b", c, a_mem_addr, a_mem_we, e_ad, e_we); end
                if (e_we) begin
                    checks++; if (a_mem_wdata !== e_wd) begin errors++; $display("FAIL rnd_wdata@%0d: got %h want %h", c, a_mem_wdata, e_wd); end
                end
            end
            if (gnt_any && c >= issue_c) begin
                checks++; if (a_owner !== e_own) begin errors++; $display("FAIL rnd_owner@%0d: got %b want %b", c, a_owner, e_own); end
            end
            if (c == ready_c && !e_we) begin
                checks++;
                if (!e_own && a_cpu_rdata !== e_rd) begin errors++; $display("FAIL rnd_cpu_rdata@%0d: got %h want %h", c, a_cpu_rdata, e_rd); end
                if (e_own && a_dma_rdata !== e_rd) begin errors++; $display("FAIL rnd_dma_rdata@%0d: got %h want %h", c, a_dma_rdata, e_rd); end
            end
            for (int m = 0; m < 2; m++) begin
                if (rdy[m]) begin
                    pend[m] = 0;
                end else if (!pend[m] && $urandom_range(0, 3) == 0) begin
                    pend[m] = 1;
                    we[m] = ($urandom_range(0, 2) == 0);
                    ad[m] = 8'($urandom_range(0, 15));
                    wd[m] = $urandom;
                end
            end
            a_cpu_req = pend[0]; cpu_we = we[0]; cpu_addr = ad[0]; cpu_wdata = wd[0];
            a_dma_req = pend[1]; dma_we = we[1]; dma_addr = ad[1]; dma_wdata = wd[1];
            if (c >= free_c && (pend[0] || pend[1])) begin
                w = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
                last = w;
                e_own = (w == 1);
                e_we = we[w]; e_ad = ad[w]; e_wd = wd[w];
                if (e_we) ref_mem[e_ad] = e_wd;
                else e_rd = ref_mem[e_ad];
                issue_c = c + 1;
                ready_c = c + LAT_A + 2;
                free_c = c + LAT_A + 3;
                gnt_any = 1;
            end
            @(negedge clk);
        end
        a_cpu_req = 1'b0; a_dma_req = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(8'(i));
        test_reset();
        test_dma_write();
        idle_ticks(2);
        test_cpu_read_lat1();
        idle_ticks(2);
        test_round_robin();
        idle_ticks(2);
        test_fixed_priority();
        idle_ticks(2);
        test_addr_change();
        idle_ticks(2);
        test_reset_mid();
        idle_ticks(2);
        test_random();
        idle_ticks(4);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
